// File: rtl/key_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, 4-state qualification FSM, registered level/strobe
// and a wrapping press counter. Define AUTO_REPEAT_EN to compile in hold-to-repeat strobes.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_CNT  = 32'd1000000,
   parameter int unsigned REPEAT_DELAY  = 32'd25000000,
   parameter int unsigned REPEAT_PERIOD = 32'd5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   output logic       key_level,
   output logic       key_pulse,
   output logic [7:0] press_cnt
);

   // DEBOUNCE_CNT of 0 behaves like 1: accept after a single stable FSM cycle.
   localparam logic [31:0] DbLast = (DEBOUNCE_CNT < 2) ? 32'd0 : 32'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  sync_q;
   logic        sync_p;
   logic        pulse_d;
   logic        rep_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], key_n};
   end

   assign sync_p = ~sync_q[1];

`ifdef AUTO_REPEAT_EN
   // Limits kept >= 2 so a repeat can never land on the cycle right after another strobe.
   localparam logic [31:0] RepDelayLast  = (REPEAT_DELAY < 3)  ? 32'd1 : 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RepPeriodLast = (REPEAT_PERIOD < 3) ? 32'd1 : 32'(REPEAT_PERIOD - 1);

   logic [31:0] rep_cnt_q, rep_cnt_d;
   logic        rep_phase_q, rep_phase_d;

   assign rep_fire = (state_q == StHeld) && sync_p &&
                     (rep_cnt_q == (rep_phase_q ? RepPeriodLast : RepDelayLast));

   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      if (state_q == StIdle) begin
         rep_cnt_d   = 32'd0;
         rep_phase_d = 1'b0;
      end else if (state_q == StHeld && sync_p) begin
         if (rep_fire) begin
            rep_cnt_d   = 32'd0;
            rep_phase_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt_q   <= 32'd0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end
`else
   logic unused_rep;
   assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign rep_fire   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (sync_p) begin
               state_d = StPressWait;
               cnt_d   = 32'd0;
            end
         end
         StPressWait: begin
            if (!sync_p) begin
               state_d = StIdle;
            end else if (cnt_q == DbLast) begin
               state_d = StHeld;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StHeld: begin
            if (!sync_p) begin
               state_d = StReleaseWait;
               cnt_d   = 32'd0;
            end else begin
               pulse_d = rep_fire;
            end
         end
         StReleaseWait: begin
            if (sync_p) begin
               state_d = StHeld;
            end else if (cnt_q == DbLast) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= 32'd0;
         key_level <= 1'b0;
         key_pulse <= 1'b0;
         press_cnt <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_level <= (state_d == StHeld) || (state_d == StReleaseWait);
         key_pulse <= pulse_d;
         if (pulse_d) press_cnt <= press_cnt + 8'd1;
      end
   end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 32'd1000000, stable-sample cycles required to accept an edge (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 32'd25000000, hold cycles from accepted press to first repeat pulse (used only with AUTO_REPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 32'd5000000, cycles between subsequent repeat pulses (used only with AUTO_REPEAT_EN).
REQ-004 clk  input  1  system clock, all state on rising edge; one clock domain only.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 key_n  input  1  raw push-button, active-low, asynchronous to clk, bouncing.
REQ-007 key_level  output  1  debounced pressed level, 1 = pressed; feeds state-machine In input.
REQ-008 key_pulse  output  1  one-clk-wide strobe per accepted press (plus repeats); feeds state-machine step.
REQ-009 press_cnt  output  8  count of key_pulse strobes since reset.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; FSM sees only synchronized value (sync_p = ~synchronized key_n).
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; 32-bit debounce counter cnt.
REQ-012 IDLE: sync_p=1 -> PRESS_WAIT, cnt<=0; else stay.
REQ-013 PRESS_WAIT: sync_p=0 -> IDLE (bounce rejected, no pulse); cnt==DEBOUNCE_CNT-1 -> HELD with key_pulse<=1; else cnt<=cnt+1.
REQ-014 HELD: sync_p=0 -> RELEASE_WAIT, cnt<=0; else stay.
REQ-015 RELEASE_WAIT: sync_p=1 -> HELD, no pulse; cnt==DEBOUNCE_CNT-1 -> IDLE; else cnt<=cnt+1.
REQ-016 key_level SHALL be registered, 1 exactly while state is HELD or RELEASE_WAIT.
REQ-017 key_pulse SHALL be registered, high for exactly one clk per qualifying event, never two consecutive cycles.
REQ-018 With key_n held low from first sample, key_pulse SHALL assert exactly DEBOUNCE_CNT+2 cycles after key_n is first sampled low; key_level rises the same cycle.
REQ-019 key_level SHALL fall DEBOUNCE_CNT+2 cycles after key_n is first sampled high following a stable press.
REQ-020 press_cnt SHALL increment by 1 on each key_pulse, wrapping 255 -> 0 without saturation.
REQ-021 Glitch shorter than DEBOUNCE_CNT cycles (after sync) SHALL produce no change on any output.
REQ-022 DEBOUNCE_CNT of 0 or 1 SHALL behave as 1 (accept after one stable FSM cycle).

Reset
REQ-023 rst=0 SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=1 (released), key_level=0, key_pulse=0, press_cnt=0, repeat counter=0.
REQ-024 Reset asserted mid-press SHALL abort without pulse; after release of rst with key_n still low, a full DEBOUNCE_CNT+2 qualification SHALL be required before key_pulse.
REQ-025 Deassertion of rst SHALL take effect on the next rising clk; no output changes during rst=0.

Configuration
REQ-026 Macro AUTO_REPEAT_EN SHALL compile in auto-repeat logic.
REQ-027 With AUTO_REPEAT_EN: in HELD, a 32-bit repeat counter SHALL emit key_pulse REPEAT_DELAY cycles after entering HELD from PRESS_WAIT, then every REPEAT_PERIOD cycles while HELD; RELEASE_WAIT freezes it, return to HELD from RELEASE_WAIT resumes without restart, IDLE clears it.
REQ-028 Without AUTO_REPEAT_EN: no repeat counter present; exactly one key_pulse per accepted press; REPEAT_* parameters ignored.

Verification
REQ-029 DEBOUNCE_CNT=4, key_n low at cycle 0 held -> key_pulse=1 only at cycle 6, key_level=1 from cycle 6, press_cnt=1.
REQ-030 DEBOUNCE_CNT=4, key_n low 3 cycles then high -> key_pulse never 1, key_level stays 0, press_cnt=0.
REQ-031 DEBOUNCE_CNT=4, stable press then key_n high for 2 cycles then low -> key_level stays 1, no second pulse, press_cnt=1.
REQ-032 DEBOUNCE_CNT=4, 256 clean press/release pairs -> 256 single-cycle pulses, press_cnt=0 at end.
REQ-033 rst pulsed low at cycle 4 of a press (key_n held low) -> outputs 0 immediately; pulse at 6 cycles after rst release.
REQ-034 AUTO_REPEAT_EN, DEBOUNCE_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, key_n held low -> pulses at cycles 6, 16, 21, 26; press_cnt=4 at cycle 26.
